// File: rtl/chicken_track_ctrl_if.sv
// Move/status bundle between the tile-match logic, the track controller and the display path.
// master drives move requests and observes state; slave is the controller side.
interface chicken_track_ctrl_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int PID_W       = 2,
    parameter int POS_W       = 5,
    parameter int STEP_W      = 5,
    parameter int CNT_W       = 3
);
    logic                         start;
    logic                         move_valid;
    logic                         move_hit;
    logic [STEP_W-1:0]            step;
    logic                         move_ready;
    logic                         move_err;
    logic                         capture;
    logic [PID_W-1:0]             cur_player;
    logic [NUM_PLAYERS*POS_W-1:0] pos_flat;
    logic [NUM_PLAYERS*CNT_W-1:0] feathers_flat;
    logic [POS_W-1:0]             afterposition_data;
    logic                         W;
    logic [PID_W-1:0]             winner;

    modport master (
        output start, move_valid, move_hit, step,
        input  move_ready, move_err, capture, cur_player, pos_flat,
               feathers_flat, afterposition_data, W, winner
    );

    modport slave (
        input  start, move_valid, move_hit, step,
        output move_ready, move_err, capture, cur_player, pos_flat,
               feathers_flat, afterposition_data, W, winner
    );
endinterface

// File: rtl/chicken_track_ctrl.sv
// Multi-player chicken track controller: holds positions and feathers, sequences turns,
// applies wrapped moves, resolves captures on landing and declares the winner.
module chicken_track_ctrl #(
    parameter int NUM_PLAYERS = 4,
    parameter int PID_W       = 2,
    parameter int TRACK_LEN   = 24,
    parameter int POS_W       = 5,
    parameter int STEP_W      = 5,
    parameter int CNT_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    chicken_track_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q      [NUM_PLAYERS];
    logic [POS_W-1:0]   pos_d      [NUM_PLAYERS];
    logic [CNT_W-1:0]   feathers_q [NUM_PLAYERS];
    logic [CNT_W-1:0]   feathers_d [NUM_PLAYERS];
    logic [PID_W-1:0]   cur_q, cur_d;
    logic [POS_W-1:0]   target_q, target_d;
    logic [POS_W-1:0]   after_q, after_d;
    logic               w_q, w_d;
    logic [PID_W-1:0]   winner_q, winner_d;
    logic               err_q, err_d;
    logic               cap_q, cap_d;

    logic [PID_W-1:0]   next_live;
    logic               found;
    logic [POS_W:0]     sum;
    logic               step_big;
    logic [CNT_W-1:0]   new_cnt;

    // First player after cur_q (cyclically) still holding feathers.
    always_comb begin
        next_live = cur_q;
        found     = 1'b0;
        for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
            if (!found && feathers_q[PID_W'((32'(cur_q) + k) % NUM_PLAYERS)] != '0) begin
                next_live = PID_W'((32'(cur_q) + k) % NUM_PLAYERS);
                found     = 1'b1;
            end
        end
    end

    assign sum      = {1'b0, pos_q[cur_q]} + (POS_W+1)'(bus.step);
    assign step_big = 32'(bus.step) >= 32'(TRACK_LEN);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        feathers_d = feathers_q;
        cur_d      = cur_q;
        target_d   = target_q;
        after_d    = after_q;
        w_d        = w_q;
        winner_d   = winner_q;
        err_d      = 1'b0;
        cap_d      = 1'b0;
        new_cnt    = feathers_q[cur_q];

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        pos_d[i]      = POS_W'(i * (TRACK_LEN / NUM_PLAYERS));
                        feathers_d[i] = CNT_W'(1);
                    end
                    cur_d    = '0;
                    w_d      = 1'b0;
                    winner_d = '0;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (bus.move_valid) begin
                    if (!bus.move_hit) begin
                        cur_d = next_live;
                    end else if (step_big) begin
                        err_d = 1'b1;
                    end else begin
                        target_d = (sum >= (POS_W+1)'(TRACK_LEN))
                                 ? POS_W'(sum - (POS_W+1)'(TRACK_LEN))
                                 : POS_W'(sum);
                        state_d  = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                pos_d[cur_q] = target_q;
                after_d      = target_q;
                // Every other live player on the landing tile loses all feathers to the mover.
                for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
                    if (PID_W'(j) != cur_q && feathers_q[PID_W'(j)] != '0
                        && pos_q[PID_W'(j)] == target_q) begin
                        new_cnt                = new_cnt + feathers_q[PID_W'(j)];
                        feathers_d[PID_W'(j)]  = '0;
                        cap_d                  = 1'b1;
                    end
                end
                feathers_d[cur_q] = new_cnt;
                if (new_cnt == CNT_W'(NUM_PLAYERS)) begin
                    w_d      = 1'b1;
                    winner_d = cur_q;
                    state_d  = DONE;
                end else begin
                    state_d  = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i]      <= POS_W'(i * (TRACK_LEN / NUM_PLAYERS));
                feathers_q[i] <= CNT_W'(1);
            end
            cur_q    <= '0;
            target_q <= '0;
            after_q  <= '0;
            w_q      <= 1'b0;
            winner_q <= '0;
            err_q    <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            feathers_q <= feathers_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            after_q    <= after_d;
            w_q        <= w_d;
            winner_q   <= winner_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
        end
    end

    always_comb begin
        bus.pos_flat      = '0;
        bus.feathers_flat = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            bus.pos_flat[i*POS_W +: POS_W]      = pos_q[i];
            bus.feathers_flat[i*CNT_W +: CNT_W] = feathers_q[i];
        end
    end

    assign bus.move_ready         = (state_q == PLAY);
    assign bus.move_err           = err_q;
    assign bus.capture            = cap_q;
    assign bus.cur_player         = cur_q;
    assign bus.afterposition_data = after_q;
    assign bus.W                  = w_q;
    assign bus.winner             = winner_q;
endmodule

// File: tb/tb_chicken_track_ctrl.sv
// Bench for chicken_track_ctrl: directed scenarios plus random games checked against
// a move-level model of the game rules.
module tb_chicken_track_ctrl;
    localparam int NP     = 4;
    localparam int PID_W  = 2;
    localparam int TL     = 24;
    localparam int POS_W  = 5;
    localparam int STEP_W = 5;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chicken_track_ctrl_if #(
        .NUM_PLAYERS(NP), .PID_W(PID_W), .POS_W(POS_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
    ) bus ();

    chicken_track_ctrl #(
        .NUM_PLAYERS(NP), .PID_W(PID_W), .TRACK_LEN(TL),
        .POS_W(POS_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: plain integers, one call per accepted move.
    int m_pos  [NP];
    int m_fth  [NP];
    int m_cur, m_after, m_win, m_winner;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    function automatic void model_init(input bit full_reset);
        for (int i = 0; i < NP; i++) begin
            m_pos[i] = i * (TL / NP);
            m_fth[i] = 1;
        end
        m_cur = 0; m_win = 0; m_winner = 0;
        if (full_reset) m_after = 0;
    endfunction

    function automatic void model_move(input bit hit, input int st,
                                       output bit e_err, output bit e_cap, output bit e_res);
        int tgt;
        e_err = 0; e_cap = 0; e_res = 0;
        if (!hit) begin
            for (int k = 1; k < NP; k++) begin
                if (m_fth[(m_cur + k) % NP] > 0) begin
                    m_cur = (m_cur + k) % NP;
                    break;
                end
            end
        end else if (st >= TL) begin
            e_err = 1;
        end else begin
            e_res = 1;
            tgt = (m_pos[m_cur] + st) % TL;
            for (int j = 0; j < NP; j++) begin
                if (j != m_cur && m_fth[j] > 0 && m_pos[j] == tgt) begin
                    m_fth[m_cur] += m_fth[j];
                    m_fth[j] = 0;
                    e_cap = 1;
                end
            end
            m_pos[m_cur] = tgt;
            m_after = tgt;
            if (m_fth[m_cur] == NP) begin
                m_win = 1;
                m_winner = m_cur;
            end
        end
    endfunction

    task automatic check_all(input string tag, input bit exp_ready);
        logic [NP*POS_W-1:0] ep;
        logic [NP*CNT_W-1:0] ef;
        int total;
        total = 0;
        for (int i = 0; i < NP; i++) begin
            ep[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
            ef[i*CNT_W +: CNT_W] = CNT_W'(m_fth[i]);
            total += int'(bus.feathers_flat[i*CNT_W +: CNT_W]);
        end
        check_eq({tag, ".pos"},    64'(bus.pos_flat),           64'(ep));
        check_eq({tag, ".fth"},    64'(bus.feathers_flat),      64'(ef));
        check_eq({tag, ".ftot"},   64'(total),                  64'(NP));
        check_eq({tag, ".cur"},    64'(bus.cur_player),         64'(m_cur));
        check_eq({tag, ".after"},  64'(bus.afterposition_data), 64'(m_after));
        check_eq({tag, ".W"},      64'(bus.W),                  64'(m_win));
        check_eq({tag, ".winner"}, 64'(bus.winner),             64'(m_winner));
        check_eq({tag, ".ready"},  64'(bus.move_ready),         64'(exp_ready));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 0; bus.move_valid = 0; bus.move_hit = 0; bus.step = '0;
        repeat (2) @(negedge clk);
        model_init(1);
        check_all("reset", 0);
        check_eq("reset.err", 64'(bus.move_err), 64'd0);
        check_eq("reset.cap", 64'(bus.capture),  64'd0);
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model_init(0);
        check_all("start", 1);
    endtask

    // One move at the negedge before the accept edge; checks at the visibility points.
    task automatic do_move(input string tag, input bit hit, input int st, input bit with_start);
        bit e_err, e_cap, e_res;
        for (int n = 0; n < 20 && !bus.move_ready; n++) @(negedge clk);
        if (!bus.move_ready) begin
            check_eq({tag, ".ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        bus.move_valid = 1'b1;
        bus.move_hit   = hit;
        bus.step       = STEP_W'(st);
        bus.start      = with_start;
        model_move(hit, st, e_err, e_cap, e_res);
        @(negedge clk);
        bus.move_valid = 1'b0;
        bus.start      = 1'b0;
        if (e_res) begin
            check_eq({tag, ".res_ready"}, 64'(bus.move_ready), 64'd0);
            @(negedge clk);
            check_eq({tag, ".cap"}, 64'(bus.capture), 64'(e_cap));
        end else begin
            check_eq({tag, ".err"}, 64'(bus.move_err), 64'(e_err));
            check_eq({tag, ".cap"}, 64'(bus.capture),  64'd0);
        end
        check_all(tag, !m_win);
    endtask

    // A move request while the controller is not in PLAY must be dropped.
    task automatic idle_move(input string tag, input bit hit, input int st);
        bus.move_valid = 1'b1;
        bus.move_hit   = hit;
        bus.step       = STEP_W'(st);
        @(negedge clk);
        bus.move_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, ".err"}, 64'(bus.move_err), 64'd0);
        check_all(tag, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.move_valid = 0; bus.move_hit = 0; bus.step = '0;

        do_reset();
        idle_move("idle_drop", 1, 6);
        do_start();
        do_move("p0_miss", 0, 0, 0);

        do_reset(); do_start();
        do_move("p0_hit6", 1, 6, 0);
        do_move("p0_miss_skip", 0, 0, 0);

        do_reset(); do_start();
        do_move("wrap_m0", 0, 0, 0);
        do_move("wrap_m1", 0, 0, 0);
        do_move("wrap_m2", 0, 0, 0);
        do_move("wrap_hit7", 1, 7, 0);
        do_move("wrap_err24", 1, 24, 0);
        do_move("step0", 1, 0, 0);

        do_reset(); do_start();
        do_move("win_a", 1, 6, 0);
        do_move("win_b", 1, 6, 0);
        do_move("win_c", 1, 6, 0);
        idle_move("done_drop", 1, 3);
        do_start();

        // Reset while RESOLVE holds a capturing target.
        do_reset(); do_start();
        for (int n = 0; n < 20 && !bus.move_ready; n++) @(negedge clk);
        bus.move_valid = 1'b1; bus.move_hit = 1'b1; bus.step = STEP_W'(6);
        @(negedge clk);
        bus.move_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        model_init(1);
        check_eq("rst_res.cap", 64'(bus.capture), 64'd0);
        check_all("rst_res", 0);
        rst = 1'b0;
        do_start();

        for (int g = 0; g < 400; g++) begin
            if (m_win) begin
                idle_move("rnd_done", 1, int'($urandom_range(0, 23)));
                do_start();
            end else begin
                automatic bit hit = ($urandom_range(0, 2) != 0);
                automatic int st  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TL, 31))
                                                                : int'($urandom_range(0, TL - 1));
                do_move("rnd", hit, st, ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
